// File: rtl/perf_event_counter.sv
// perf_event_counter: run-cycle and per-event counters with a cycle budget,
// sticky overflow flags and a snapshot bank read back through a registered mux.
module perf_event_counter #(
  parameter int NUM_EVT    = 4,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 64,
  parameter int SATURATE   = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         clear_i,
  input  logic [NUM_EVT-1:0]           evt_i,
  input  logic                         snap_i,
  input  logic [$clog2(NUM_EVT+1)-1:0] rd_sel_i,
  output logic [CNT_W-1:0]             rd_data_o,
  output logic                         snap_valid_o,
  output logic                         running_o,
  output logic                         done_o,
  output logic [NUM_EVT:0]             ovf_o
);

  localparam int NUM_CNT = NUM_EVT + 1;
  localparam int SEL_W   = $clog2(NUM_EVT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  if ((NUM_EVT < 1) || (NUM_EVT > 16)) begin : g_bad_num_evt
    $error("perf_event_counter: NUM_EVT must be in 1..16");
  end

  // The budget must be representable in a CNT_W-bit counter.
  if ((CNT_W < 63) && (64'(MAX_CYCLES) >= (64'd1 << CNT_W))) begin : g_bad_max_cycles
    $error("perf_event_counter: MAX_CYCLES does not fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt      [NUM_CNT];
  logic [CNT_W-1:0] cnt_next [NUM_CNT];
  logic [CNT_W-1:0] snap     [NUM_CNT];
  logic [NUM_EVT:0] inc;
  logic [NUM_EVT:0] ovf_next;
  logic [CNT_W-1:0] rd_mux;
  logic             budget_hit;

  // Slot 0 is the cycle counter; slot k counts event k-1.
  assign inc = (state == RUN) ? {evt_i, 1'b1} : '0;

  always_comb begin
    ovf_next = ovf_o;
    for (int k = 0; k < NUM_CNT; k++) begin
      cnt_next[k] = cnt[k];
      if (clear_i) begin
        cnt_next[k] = '0;
      end else if (inc[k]) begin
        if (cnt[k] == ALL_ONES) begin
          ovf_next[k] = 1'b1;
          cnt_next[k] = (SATURATE != 0) ? ALL_ONES : '0;
        end else begin
          cnt_next[k] = cnt[k] + CNT_W'(1);
        end
      end
    end
    if (clear_i) begin
      ovf_next = '0;
    end
  end

  // Budget exhaustion wins over a pause requested on the same edge.
  always_comb begin
    budget_hit = (MAX_CYCLES != 0) && !clear_i && (cnt_next[0] == MAX_CNT);
    state_next = state;
    unique case (state)
      IDLE: if (start_i && !clear_i) state_next = RUN;
      RUN: begin
        if (budget_hit)    state_next = DONE;
        else if (!start_i) state_next = IDLE;
      end
      DONE: if (clear_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (rd_sel_i == SEL_W'(k)) rd_mux = snap[k];
    end
  end

  // Snapshots take the pre-increment, pre-clear live values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      ovf_o        <= '0;
      snap_valid_o <= 1'b0;
      rd_data_o    <= '0;
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt[k]  <= '0;
        snap[k] <= '0;
      end
    end else begin
      state        <= state_next;
      ovf_o        <= ovf_next;
      snap_valid_o <= snap_i;
      rd_data_o    <= rd_mux;
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt[k] <= cnt_next[k];
        if (snap_i) snap[k] <= cnt[k];
      end
    end
  end

  assign running_o = (state == RUN);
  assign done_o    = (state == DONE);

endmodule

// File: tb/tb_perf_event_counter.sv
// tb_perf_event_counter: directed scenarios plus random traffic on three configurations
// (default, 4-bit saturating, 4-bit wrapping) sharing one stimulus, against a reference model.
module tb_perf_event_counter;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  logic        clk = 1'b0;
  logic        rst, start, clear, snap;
  logic [3:0]  evt;
  logic [2:0]  sel;
  logic [31:0] rd_main;
  logic [3:0]  rd_sat, rd_wrap;
  logic [2:0]  running, done, snap_valid;
  logic [4:0]  ovf [3];

  int checks = 0;
  int errors = 0;

  int cfg_w   [3] = '{32, 4, 4};
  int cfg_max [3] = '{64, 0, 0};
  bit cfg_sat [3] = '{1'b1, 1'b1, 1'b0};

  longint unsigned m_cnt  [3][5];
  longint unsigned m_snap [3][5];
  longint unsigned m_rd   [3];
  logic [4:0]      m_ovf  [3];
  int              m_phase[3];
  logic            m_sv;

  always #5 clk = ~clk;

  perf_event_counter #(.NUM_EVT(4), .CNT_W(32), .MAX_CYCLES(64), .SATURATE(1)) dut_main (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt), .snap_i(snap),
    .rd_sel_i(sel), .rd_data_o(rd_main), .snap_valid_o(snap_valid[0]),
    .running_o(running[0]), .done_o(done[0]), .ovf_o(ovf[0]));

  perf_event_counter #(.NUM_EVT(4), .CNT_W(4), .MAX_CYCLES(0), .SATURATE(1)) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt), .snap_i(snap),
    .rd_sel_i(sel), .rd_data_o(rd_sat), .snap_valid_o(snap_valid[1]),
    .running_o(running[1]), .done_o(done[1]), .ovf_o(ovf[1]));

  perf_event_counter #(.NUM_EVT(4), .CNT_W(4), .MAX_CYCLES(0), .SATURATE(0)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt), .snap_i(snap),
    .rd_sel_i(sel), .rd_data_o(rd_wrap), .snap_valid_o(snap_valid[2]),
    .running_o(running[2]), .done_o(done[2]), .ovf_o(ovf[2]));

  // Reference: counts as plain integers limited to 2^W-1, phase as a small integer.
  function automatic void model_update();
    for (int c = 0; c < 3; c++) begin
      longint unsigned lim = (64'd1 << cfg_w[c]) - 64'd1;
      bit was_run = (m_phase[c] == PH_RUN);
      if (!rst) begin
        m_phase[c] = PH_IDLE;
        m_rd[c]    = 0;
        m_ovf[c]   = '0;
        for (int k = 0; k < 5; k++) begin
          m_cnt[c][k]  = 0;
          m_snap[c][k] = 0;
        end
      end else begin
        m_rd[c] = (sel <= 3'd4) ? m_snap[c][sel] : 0;
        if (snap) for (int k = 0; k < 5; k++) m_snap[c][k] = m_cnt[c][k];
        if (clear) begin
          m_ovf[c] = '0;
          for (int k = 0; k < 5; k++) m_cnt[c][k] = 0;
        end else if (was_run) begin
          for (int k = 0; k < 5; k++) begin
            if (k == 0 || evt[k-1]) begin
              if (m_cnt[c][k] == lim) begin
                m_ovf[c][k] = 1'b1;
                m_cnt[c][k] = cfg_sat[c] ? lim : 0;
              end else begin
                m_cnt[c][k] = m_cnt[c][k] + 1;
              end
            end
          end
        end
        if (m_phase[c] == PH_IDLE) begin
          if (start && !clear) m_phase[c] = PH_RUN;
        end else if (m_phase[c] == PH_RUN) begin
          if (cfg_max[c] != 0 && !clear && m_cnt[c][0] == longint'(cfg_max[c])) m_phase[c] = PH_DONE;
          else if (!start) m_phase[c] = PH_IDLE;
        end else begin
          if (clear) m_phase[c] = PH_IDLE;
        end
      end
    end
    m_sv = rst ? snap : 1'b0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    logic [63:0] rd_obs [3];
    rd_obs[0] = 64'(rd_main);
    rd_obs[1] = 64'(rd_sat);
    rd_obs[2] = 64'(rd_wrap);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("running[%0d]", c), 64'(running[c]), 64'(m_phase[c] == PH_RUN));
      check($sformatf("done[%0d]", c), 64'(done[c]), 64'(m_phase[c] == PH_DONE));
      check($sformatf("snap_valid[%0d]", c), 64'(snap_valid[c]), 64'(m_sv));
      check($sformatf("ovf[%0d]", c), 64'(ovf[c]), 64'(m_ovf[c]));
      check($sformatf("rd_data[%0d]", c), rd_obs[c], 64'(m_rd[c]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_output();
  endtask

  task automatic apply_stimulus(input logic r, input logic s, input logic c,
                                input logic [3:0] e, input logic sn, input logic [2:0] sl);
    rst = r; start = s; clear = c; evt = e; snap = sn; sel = sl;
  endtask

  initial begin
    int n;
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0);
    step();
    step();
    check("reset_rd", 64'(rd_main), 64'd0);
    check("reset_running", 64'(running), 64'd0);

    // T1: budget of 64 edges, event 0 every third counted edge.
    apply_stimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 3'd0);
    step();
    check("t1_enter_running", 64'(running[0]), 64'd1);
    for (int i = 0; i < 64; i++) begin
      logic [3:0] e = 4'($urandom);
      e[0] = (i % 3 == 0);
      evt = e;
      step();
      if (i == 62) begin
        check("t1_pre_running", 64'(running[0]), 64'd1);
        check("t1_pre_done", 64'(done[0]), 64'd0);
      end
    end
    check("t1_done", 64'(done[0]), 64'd1);
    check("t1_running_fell", 64'(running[0]), 64'd0);
    evt = 4'd0; snap = 1'b1;
    step();
    check("t1_snap_valid", 64'(snap_valid[0]), 64'd1);
    snap = 1'b0;
    step();
    check("t1_cycle", 64'(rd_main), 64'd64);
    check("t1_snap_valid_drop", 64'(snap_valid[0]), 64'd0);
    sel = 3'd1;
    step();
    check("t1_evt0", 64'(rd_main), 64'd22);
    check("t1_start_ignored", 64'(done[0]), 64'd1);

    // T6: clear in DONE, then a complete second budget.
    clear = 1'b1;
    step();
    check("t6_done_cleared", 64'(done[0]), 64'd0);
    clear = 1'b0; snap = 1'b1;
    step();
    snap = 1'b0; sel = 3'd0;
    step();
    check("t6_cycle_zeroed", 64'(rd_main), 64'd0);
    for (n = 0; n < 200 && !done[0]; n++) begin
      evt = 4'($urandom);
      step();
    end
    check("t6_budget_edges", 64'(n), 64'd63);
    check("t6_done", 64'(done[0]), 64'd1);

    // T2: pause after 10 counted edges, then resume to the budget.
    apply_stimulus(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 3'd0);
    step();
    clear = 1'b0; start = 1'b1;
    step();
    repeat (9) begin
      evt = 4'($urandom);
      step();
    end
    start = 1'b0;
    step();
    check("t2_paused", 64'(running[0]), 64'd0);
    repeat (2) step();
    snap = 1'b1;
    step();
    snap = 1'b0;
    step();
    check("t2_pause_cycle", 64'(rd_main), 64'd10);
    start = 1'b1;
    for (n = 0; n < 200 && !done[0]; n++) begin
      evt = 4'($urandom);
      step();
    end
    check("t2_resume_edges", 64'(n), 64'd55);
    snap = 1'b1;
    step();
    snap = 1'b0;
    step();
    check("t2_final_cycle", 64'(rd_main), 64'd64);

    // T4: snapshot and clear on the same edge at cycle 37.
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    repeat (37) begin
      evt = 4'($urandom);
      step();
    end
    snap = 1'b1; clear = 1'b1;
    step();
    check("t4_snap_valid", 64'(snap_valid[0]), 64'd1);
    check("t4_still_running", 64'(running[0]), 64'd1);
    snap = 1'b0; clear = 1'b0;
    step();
    check("t4_snap_cycle", 64'(rd_main), 64'd37);
    check("t4_snap_valid_drop", 64'(snap_valid[0]), 64'd0);
    snap = 1'b1;
    step();
    snap = 1'b0;
    step();
    check("t4_live_after_clear", 64'(rd_main), 64'd1);

    // T3/T3b: event 1 constantly for 20 counted edges on the 4-bit instances.
    apply_stimulus(1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 3'd0);
    step();
    rst = 1'b1;
    step();
    repeat (20) step();
    snap = 1'b1;
    step();
    snap = 1'b0; sel = 3'd2;
    step();
    check("t3_sat_evt1", 64'(rd_sat), 64'd15);
    check("t3_sat_ovf", 64'(ovf[1][2]), 64'd1);
    check("t3b_wrap_evt1", 64'(rd_wrap), 64'd4);
    check("t3b_wrap_ovf", 64'(ovf[2][2]), 64'd1);
    check("t3_main_evt1", 64'(rd_main), 64'd20);

    // Random traffic, including out-of-range read selects.
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(1'b1, ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
                     4'($urandom), ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
      step();
    end

    // T5: reset in the middle of a run with nonzero state.
    apply_stimulus(1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 3'd0);
    step();
    clear = 1'b0;
    step();
    repeat (5) begin
      evt = 4'($urandom);
      step();
    end
    snap = 1'b1;
    step();
    check("t5_pre_running", 64'(running[0]), 64'd1);
    rst = 1'b0;
    step();
    check("t5_rd", 64'(rd_main), 64'd0);
    check("t5_running", 64'(running), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_snap_valid", 64'(snap_valid), 64'd0);
    check("t5_ovf", 64'(ovf[0]), 64'd0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd1);
    step();
    check("t5_snapshot_cleared", 64'(rd_main), 64'd0);
    snap = 1'b1;
    step();
    snap = 1'b0; sel = 3'd0;
    step();
    check("t5_live_cleared", 64'(rd_main), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: still running at %0t, expected to finish before 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
